tone_detect_ctrl: RTL
=====================

Name: tone_detect_ctrl

Overview:
- Frame-level sequencer for the 13-input tone comparator `comp`.
- Collects one frame of bin magnitudes from the upstream spectral engine, one bin per beat.
  - Bin 0 is total energy; bins 1-6 are reference tones; bins 7-12 are target tones.
- Presents the full frame to `comp` and issues its enable, then captures the registered verdict.
- Applies hit/miss hysteresis across frames to produce a stable detect flag for the system controller.

Parameters:
- MAG_W, 31, magnitude width; must match `comp` inputs.
- HIT_N, 3, consecutive hit frames needed to assert detect (1..15).
- MISS_N, 4, consecutive miss frames needed to deassert detect (1..15).
- TMO_CYC, 4, cycles to wait for `comp_out_en` before abort (2..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  pulse; begins a new frame.
- bin_valid  in  1  bin beat valid.
- bin_idx  in  4  bin number, 0..12.
- bin_mag  in  MAG_W  bin magnitude.
- mags  out  13*MAG_W  packed frame; bin k at [k*MAG_W +: MAG_W]; wires to `comp` din..din12.
- comp_in_en  out  1  one-cycle enable to `comp`.
- comp_is_large  in  1  verdict from `comp`.
- comp_out_en  in  1  verdict valid from `comp` (1-cycle latency).
- frame_done  out  1  pulse; one frame decided.
- frame_hit  out  1  verdict of the last decided frame.
- detect  out  1  hysteresis output.
- err  out  1  pulse; frame aborted (incomplete, overrun, or timeout).

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - State IDLE; `mags` = 0; bin-seen mask = 0; hit and miss counters = 0.
  - `comp_in_en`, `frame_done`, `frame_hit`, `detect`, `err` all = 0.
  - Reset mid-frame or mid-compare discards everything; a `comp_out_en` arriving after reset is ignored.
- States: IDLE, COLLECT, COMPARE, WAIT, DECIDE.
- IDLE:
  - `frame_start` -> COLLECT and clears the 13-bit seen mask.
  - `bin_valid` beats are dropped silently.
- COLLECT, on each `bin_valid`:
  - idx <= 12: write `mags[idx]` and set `seen[idx]`.
  - Duplicate idx overwrites (last write wins).
  - idx > 12 is ignored.
- COLLECT exits:
  - When `seen` becomes all-ones, including on the beat that completes it: -> COMPARE next cycle.
  - `frame_start` with the mask incomplete: `err` pulse; the mask is cleared and collection restarts (stay COLLECT).
  - `frame_start` and the completing beat in the same cycle: the beat completes the frame; `frame_start` is ignored.
- COMPARE:
  - `comp_in_en` = 1 for exactly one cycle, with `mags` stable.
  - -> WAIT; the timeout counter is loaded.
- WAIT:
  - `mags` is held constant.
  - `comp_out_en` -> latch `comp_is_large`, go to DECIDE.
  - Counter expires after TMO_CYC cycles with no `comp_out_en` -> `err` pulse, IDLE; hysteresis counters unchanged.
  - `bin_valid` or `frame_start` in COMPARE/WAIT/DECIDE: dropped, with an `err` pulse (overrun); the frame in progress still completes.
- DECIDE (1 cycle):
  - `frame_done` = 1 and `frame_hit` = latched verdict.
  - Hit: miss_cnt <= 0; hit_cnt saturates at 15.
  - Miss: hit_cnt <= 0; miss_cnt saturates at 15.
  - `detect` rises when hit_cnt reaches HIT_N (counting the current frame).
  - `detect` falls when miss_cnt reaches MISS_N.
  - `detect` is otherwise held.
  - Then -> IDLE.
- Latency: last bin beat at cycle T -> `comp_in_en` at T+1 -> `comp_out_en` at T+2 -> `frame_done`, `frame_hit`, `detect` update visible at T+3.
- Back-to-back frames: `frame_start` is accepted in IDLE at T+4 at the earliest.
- `err` is a single-cycle pulse.
  - Multiple error causes in one cycle give one pulse.
  - Multiple error causes never change the state transition described above.

Decomposition:
- Shared package `tone_pkg`:
  - NUM_BINS = 13, TOTAL_BIN = 0, REF_BINS = 1..6, TGT_BINS = 7..12, MAG_W default.
  - State enum typedef.
- Natural sub-module: `tone_hyst` — hit/miss counters plus the detect flop.
  - Inputs: `clk`, `rst`, `upd`, `hit`.
  - Output: `detect`.
- The frame collector and FSM stay in the top level.
- `comp` is instantiated by the parent, not inside this block.

Test Plan:
- Full frame in order:
  - Stimulus: bin 0 = 1000, bins 1-6 = 10, bin 7 = 900, bins 8-12 = 5; `comp` model returns 1.
  - Required: `comp_in_en` one cycle after bin 12; `frame_done` with `frame_hit` = 1 at T+3; `mags` slices match.
- Hysteresis (HIT_N = 3, MISS_N = 4):
  - Hits 1,1,0,1,1,1 -> `detect` rises only on frame 6.
  - Then 0,0,0,1,0,0,0,0 -> `detect` falls only on the last frame.
- Out-of-order and duplicate bins:
  - Bins 12..0 reversed, with bin 5 sent twice (values 7 then 9) -> `mags[5]` = 9; exactly one `comp_in_en`.
- Incomplete frame:
  - 10 bins, then `frame_start` -> `err` pulse, no `comp_in_en`.
  - A following full frame decides normally.
- Timeout and overrun:
  - `comp` model never asserts `out_en` (TMO_CYC = 4) -> `err` 4 cycles after `comp_in_en`, IDLE, `detect` unchanged.
  - `bin_valid` during WAIT -> `err`, `mags` unchanged.
- Reset mid-WAIT:
  - `rst` for 1 cycle while in WAIT; late `comp_out_en` afterwards -> no `frame_done`.
  - All outputs 0; counters cleared.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the tone-detect frame sequencer: bin layout and FSM states.
package tone_pkg;

    localparam int NUM_BINS  = 13;
    localparam int TOTAL_BIN = 0;
    localparam int REF_FIRST = 1;
    localparam int REF_LAST  = 6;
    localparam int TGT_FIRST = 7;
    localparam int TGT_LAST  = 12;
    localparam int MAG_W_DEF = 31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_COMPARE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DECIDE  = 3'd4
    } state_e;

endpackage

// File: rtl/tone_hyst.sv
// Hit/miss hysteresis across decided frames; detect flips only after a run of agreeing verdicts.
module tone_hyst #(
    parameter int HIT_N  = 3,
    parameter int MISS_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic upd,
    input  logic hit,
    output logic detect
);

    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic       detect_q, detect_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        detect_d   = detect_q;
        if (upd) begin
            if (hit) begin
                miss_cnt_d = 4'd0;
                hit_cnt_d  = (hit_cnt_q == 4'd15) ? 4'd15 : hit_cnt_q + 4'd1;
                if (hit_cnt_d >= 4'(HIT_N)) begin
                    detect_d = 1'b1;
                end
            end else begin
                hit_cnt_d  = 4'd0;
                miss_cnt_d = (miss_cnt_q == 4'd15) ? 4'd15 : miss_cnt_q + 4'd1;
                if (miss_cnt_d >= 4'(MISS_N)) begin
                    detect_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 4'd0;
            miss_cnt_q <= 4'd0;
            detect_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            detect_q   <= detect_d;
        end
    end

    assign detect = detect_q;

endmodule

// File: rtl/tone_detect_ctrl.sv
// Frame sequencer: gathers 13 bin magnitudes, fires the comparator once, applies hysteresis.
// Handshake: a bin beat is consumed on any cycle with bin_valid=1 (no backpressure); comp_out_en is a one-cycle verdict strobe.
module tone_detect_ctrl
    import tone_pkg::*;
#(
    parameter int MAG_W   = MAG_W_DEF,
    parameter int HIT_N   = 3,
    parameter int MISS_N  = 4,
    parameter int TMO_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      bin_valid,
    input  logic [3:0]                bin_idx,
    input  logic [MAG_W-1:0]          bin_mag,
    output logic [NUM_BINS*MAG_W-1:0] mags,
    output logic                      comp_in_en,
    input  logic                      comp_is_large,
    input  logic                      comp_out_en,
    output logic                      frame_done,
    output logic                      frame_hit,
    output logic                      detect,
    output logic                      err,
    output state_e                    state_dbg
);

    localparam logic [NUM_BINS-1:0] ALL_SEEN = {NUM_BINS{1'b1}};

    state_e                    state_q, state_d;
    logic [NUM_BINS-1:0]       seen_q, seen_d;
    logic [NUM_BINS*MAG_W-1:0] mags_q, mags_d;
    logic [3:0]                tmo_q, tmo_d;
    logic                      hit_q, hit_d;
    logic                      upd;
    logic                      err_c;
    logic                      beat_ok;
    logic [NUM_BINS-1:0]       beat_mask;
    logic [NUM_BINS-1:0]       seen_upd;

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        mags_d    = mags_q;
        tmo_d     = tmo_q;
        hit_d     = hit_q;
        upd       = 1'b0;
        err_c     = 1'b0;
        beat_ok   = bin_valid && (bin_idx < 4'(NUM_BINS));
        beat_mask = beat_ok ? (13'b1 << bin_idx) : '0;
        seen_upd  = seen_q | beat_mask;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_COLLECT;
                    seen_d  = '0;
                end
            end
            ST_COLLECT: begin
                for (int k = 0; k < NUM_BINS; k++) begin
                    if (beat_ok && (bin_idx == 4'(k))) begin
                        mags_d[k*MAG_W +: MAG_W] = bin_mag;
                    end
                end
                seen_d = seen_upd;
                // A completing beat wins over a simultaneous frame_start.
                if (seen_upd == ALL_SEEN) begin
                    state_d = ST_COMPARE;
                end else if (frame_start) begin
                    err_c  = 1'b1;
                    seen_d = '0;
                end
            end
            ST_COMPARE: begin
                tmo_d   = 4'(TMO_CYC);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (comp_out_en) begin
                    hit_d   = comp_is_large;
                    upd     = 1'b1;
                    state_d = ST_DECIDE;
                end else if (tmo_q == 4'd1) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - 4'd1;
                end
            end
            ST_DECIDE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Overrun: input arriving while a frame is being compared is dropped.
        if ((state_q == ST_COMPARE || state_q == ST_WAIT || state_q == ST_DECIDE) &&
            (bin_valid || frame_start)) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seen_q  <= '0;
            mags_q  <= '0;
            tmo_q   <= 4'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            mags_q  <= mags_d;
            tmo_q   <= tmo_d;
            hit_q   <= hit_d;
        end
    end

    // Counters update on the verdict edge so detect is visible alongside frame_done.
    tone_hyst #(
        .HIT_N  (HIT_N),
        .MISS_N (MISS_N)
    ) u_hyst (
        .clk    (clk),
        .rst    (rst),
        .upd    (upd),
        .hit    (comp_is_large),
        .detect (detect)
    );

    assign mags       = mags_q;
    assign comp_in_en = (state_q == ST_COMPARE);
    assign frame_done = (state_q == ST_DECIDE);
    assign frame_hit  = hit_q;
    assign err        = err_c;
    assign state_dbg  = state_q;

endmodule
